alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command-side controller for the 8-bit ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's function and operand inputs from registers. It samples the ALU result and flags, maintains the architectural accumulator, and returns a response. Its 2-bit state uses the same encoding the ALU uses for its state: READY=0, ARITH=1, LOGIC=2, ERROR=3.

## Interface
- No parameters; all datapaths are 8-bit and the function code is 3-bit.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  sequencer can accept a request
- cmd_funct  in  3  ALU function code: 0 add, 1 sub, 2 shl, 3 shr, 4 and, 5 or, 6 xor, 7 not
- cmd_a  in  8  operand A, used when cmd_use_acc=0
- cmd_b  in  8  operand B
- cmd_use_acc  in  1  1 selects the accumulator as operand A
- alu_funct  out  8→3  registered function code to the ALU (3 bits)
- alu_a, alu_b  out  8  registered operands to the ALU
- alu_out  in  8  ALU result (combinational)
- alu_carry  in  1  ALU shift carry
- alu_overflow  in  1  ALU add/sub overflow
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  8  sampled alu_out
- rsp_err  out  1  operation faulted
- rsp_flags  out  2  {carry, overflow} as sampled
- acc  out  8  accumulator
- seq_state  out  2  current state
- err_clear  in  1  leave the ERROR state
- op_count  out  8  successful operations, wraps
- err_count  out  8  faulted operations, saturates at 0xFF

## Operation
- **READY (0):**
  - cmd_ready = (seq_state==READY) && !rsp_valid.
  - On cmd_valid && cmd_ready, register alu_funct <= cmd_funct, alu_a <= (cmd_use_acc ? acc : cmd_a), and alu_b <= cmd_b.
  - Go to ARITH if cmd_funct<4, otherwise to LOGIC.
- **ARITH (1), one cycle:**
  - Fault = alu_overflow for funct 0 or 1; fault = alu_carry for funct 2 or 3.
  - At the clock edge, capture rsp_data <= alu_out, rsp_flags <= {alu_carry, alu_overflow}, rsp_err <= fault, and set rsp_valid <= 1.
  - No fault: acc <= alu_out, op_count++, go to READY.
  - Fault: acc unchanged, err_count++ (saturating), go to ERROR.
- **LOGIC (2), one cycle:**
  - Never faults and never reads the flags.
  - Capture rsp_flags <= 2'b00.
  - acc <= alu_out, op_count++, rsp_valid <= 1, rsp_err <= 0, go to READY.
- **ERROR (3):**
  - cmd_ready=0.
  - Stays in ERROR until err_clear=1 is sampled, then goes to READY. acc is not modified.
  - err_clear in any other state is ignored.
- **Response handshake:**
  - rsp_valid holds, and all rsp_* fields stay stable, until the cycle in which rsp_ready=1. rsp_valid clears at that edge.
  - rsp_ready with rsp_valid=0 has no effect.
- **Simultaneous events:**
  - err_clear while rsp_valid=1 in ERROR: go to READY, and the pending error response remains valid.
  - A new command is not accepted in the same cycle as the response handshake, because cmd_ready is computed from the registered rsp_valid.
- **Accumulator chaining:** cmd_use_acc samples acc as registered at the accept edge. That is always the value from the prior completed op, since at most one op is in flight.

## Timing
- **Reset (asynchronous, rst_n=0):**
  - seq_state=READY, acc=0x00, alu_funct=0, alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, rsp_flags=0.
  - op_count=0, err_count=0.
  - Any in-flight op is discarded with no response.
  - On release, cmd_ready=1 in the first cycle.
- **Latency:** accept at edge N → execute state during cycle N+1 → rsp_valid=1 and acc updated after edge N+1.
- **Throughput:** one op per 3 cycles when rsp_ready is held at 1 (accept, execute, response handshake).
- **Counter boundaries:** op_count goes 0xFF→0x00; err_count stays at 0xFF.
- **ALU timing:** alu_* outputs are registered and change only at the accept edge. The ALU path must settle within one cycle.

## Test plan
The bench ALU model is combinational:
- out = A op B.
- overflow = unsigned carry-out for add, borrow for sub.
- carry = the bit shifted out for shl/shr.

Directed scenarios:
- Reset → all outputs as listed, cmd_ready=1, seq_state=0.
- add 0x10+0x20 (use_acc=0) → seq_state goes 0→1→0, rsp_data=0x30, rsp_err=0, acc=0x30, op_count=1, with rsp_valid one cycle after accept.
- Chain: add 0x05+0x03, then xor with use_acc=1 and b=0xFF → second response rsp_data=0xF7, acc=0xF7, seq_state passes through 2.
- add 0xFF+0x01 → rsp_err=1, rsp_flags=01, acc unchanged, seq_state=3, cmd_ready=0, err_count=1. Then pulse err_clear → READY.
- Hold rsp_ready=0 for 5 cycles after a response → rsp_* stable and cmd_ready=0. Raise rsp_ready → rsp_valid clears next edge and cmd_ready=1 the following cycle.
- Assert rst_n=0 during the ARITH cycle → no response, acc=0, state=READY. Also: 256 successful logic ops → op_count wraps to 0x00.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side controller for the 8-bit ALU.
// Accepts one operation at a time and drives registered function and operand
// values to the ALU. It samples the ALU result and flags one cycle later,
// maintains the accumulator and the op/error counters, and holds the response
// until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. A producer holds valid and its payload stable until that edge.
// Ready may depend on registered state only.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_funct,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_acc,
    output logic [2:0] alu_funct,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [1:0] rsp_flags,
    output logic [7:0] acc,
    output logic [1:0] seq_state,
    input  logic       err_clear,
    output logic [7:0] op_count,
    output logic [7:0] err_count
);

    // State encoding shared with the ALU's own state field.
    localparam logic [1:0] READY = 2'd0;
    localparam logic [1:0] ARITH = 2'd1;
    localparam logic [1:0] LOGIC = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    logic [1:0] state;
    logic [1:0] nextState;
    logic       accept;
    logic       execDone;
    logic       fault;
    logic       opOk;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= READY;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. Arithmetic codes are 0..3 and logic codes are 4..7.
    always_comb begin
        nextState = state;
        case (state)
            READY: if (accept) nextState = cmd_funct[2] ? LOGIC : ARITH;
            ARITH: nextState = fault ? ERROR : READY;
            LOGIC: nextState = READY;
            ERROR: if (err_clear) nextState = READY;
            default: nextState = READY;
        endcase
    end

    // Output and control decode. cmd_ready uses only registered signals, so a
    // response handshake and a new accept can never happen in the same cycle.
    always_comb begin
        cmd_ready = (state == READY) && !rsp_valid;
        accept    = cmd_valid && cmd_ready;
        execDone  = (state == ARITH) || (state == LOGIC);
        fault     = 1'b0;
        if (state == ARITH) begin
            // Shifts (codes 2 and 3) fault on carry. Add and sub fault on overflow.
            fault = alu_funct[1] ? alu_carry : alu_overflow;
        end
        opOk      = execDone && !fault;
        seq_state = state;
    end

    // Operand registers feeding the ALU. They change only at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_funct <= 3'd0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
        end else if (accept) begin
            alu_funct <= cmd_funct;
            alu_a     <= cmd_use_acc ? acc : cmd_a;
            alu_b     <= cmd_b;
        end
    end

    // Response capture at the end of the execute cycle. The response is then
    // held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            rsp_flags <= 2'b00;
        end else if (execDone) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_err   <= fault;
            rsp_flags <= (state == ARITH) ? {alu_carry, alu_overflow} : 2'b00;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Accumulator and counters. A faulted op leaves acc untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 8'h00;
            op_count  <= 8'h00;
            err_count <= 8'h00;
        end else begin
            if (opOk) begin
                acc      <= alu_out;
                op_count <= op_count + 8'd1;
            end
            if (fault && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. A combinational ALU model answers the DUT's
// operand registers. Expected responses come from a reference model that
// works from the command fields, a shadow accumulator and shadow counters.
module tb_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_funct;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;
    logic [2:0] alu_funct;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [1:0] rsp_flags;
    logic [7:0] acc;
    logic [1:0] seq_state;
    logic       err_clear;
    logic [7:0] op_count;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_acc;
    logic [7:0] m_op;
    logic [7:0] m_err;
    logic [7:0] exp_q[$];

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct(cmd_funct),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_flags(rsp_flags), .acc(acc),
        .seq_state(seq_state), .err_clear(err_clear),
        .op_count(op_count), .err_count(err_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // 8-bit ALU: add/sub flag unsigned carry/borrow on overflow, shifts by one
    // flag the bit shifted out on carry.
    function automatic void alu_calc(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] r, output logic cy, output logic ov);
        logic [8:0] t;
        r  = 8'h00;
        cy = 1'b0;
        ov = 1'b0;
        t  = 9'h000;
        case (f)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; ov = t[8]; end
            3'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; ov = t[8]; end
            3'd2: begin r = {a[6:0], 1'b0}; cy = a[7]; end
            3'd3: begin r = {1'b0, a[7:1]}; cy = a[0]; end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = ~a;
        endcase
    endfunction

    always_comb begin
        alu_calc(alu_funct, alu_a, alu_b, alu_out, alu_carry, alu_overflow);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        m_op  = 8'h00;
        m_err = 8'h00;
        exp_q.delete();
    endtask

    // driver + scoreboard for one complete operation
    task automatic do_op(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic use_acc, input int hold, input logic clear_early);
        int         budget;
        logic [7:0] op_a;
        logic [7:0] res;
        logic       cy;
        logic       ov;
        logic       flt;
        logic [1:0] e_flags;
        logic [1:0] e_state;
        logic [7:0] held;
        budget = 0;
        while (!cmd_ready && budget < 20) begin
            tick();
            budget++;
        end
        check("cmd_ready_wait", {7'd0, cmd_ready}, 8'd1);

        op_a = use_acc ? m_acc : a;
        alu_calc(f, op_a, b, res, cy, ov);
        flt     = (f < 3'd4) ? ((f < 3'd2) ? ov : cy) : 1'b0;
        e_flags = (f < 3'd4) ? {cy, ov} : 2'b00;
        exp_q.push_back(res);

        cmd_valid = 1'b1; cmd_funct = f; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
        tick();
        cmd_valid = 1'b0; cmd_a = $urandom; cmd_b = $urandom;
        check("exec_state", {6'd0, seq_state}, (f < 3'd4) ? 8'd1 : 8'd2);
        check("exec_no_rsp", {7'd0, rsp_valid}, 8'd0);
        check("alu_a", alu_a, op_a);
        check("alu_funct", {5'd0, alu_funct}, {5'd0, f});

        tick();
        if (flt) begin
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
            e_state = 2'd3;
        end else begin
            m_acc   = res;
            m_op    = m_op + 8'd1;
            e_state = 2'd0;
        end
        held = exp_q.pop_front();
        check("rsp_valid", {7'd0, rsp_valid}, 8'd1);
        check("rsp_data", rsp_data, held);
        check("rsp_err", {7'd0, rsp_err}, {7'd0, flt});
        check("rsp_flags", {6'd0, rsp_flags}, {6'd0, e_flags});
        check("acc", acc, m_acc);
        check("op_count", op_count, m_op);
        check("err_count", err_count, m_err);
        check("post_state", {6'd0, seq_state}, {6'd0, e_state});
        check("cmd_ready_busy", {7'd0, cmd_ready}, 8'd0);

        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {7'd0, rsp_valid}, 8'd1);
            check("hold_data", rsp_data, held);
            check("hold_err", {7'd0, rsp_err}, {7'd0, flt});
            check("hold_flags", {6'd0, rsp_flags}, {6'd0, e_flags});
            check("hold_cmd_ready", {7'd0, cmd_ready}, 8'd0);
        end

        if (flt && clear_early) begin
            err_clear = 1'b1;
            tick();
            err_clear = 1'b0;
            check("early_clr_state", {6'd0, seq_state}, 8'd0);
            check("early_clr_valid", {7'd0, rsp_valid}, 8'd1);
            check("early_clr_err", {7'd0, rsp_err}, 8'd1);
            check("early_clr_ready", {7'd0, cmd_ready}, 8'd0);
            e_state = 2'd0;
        end

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_cleared", {7'd0, rsp_valid}, 8'd0);
        check("cmd_ready_after", {7'd0, cmd_ready}, (e_state == 2'd0) ? 8'd1 : 8'd0);

        if (e_state == 2'd3) begin
            tick();
            check("err_sticky", {6'd0, seq_state}, 8'd3);
            err_clear = 1'b1;
            tick();
            err_clear = 1'b0;
            check("clr_state", {6'd0, seq_state}, 8'd0);
            check("clr_cmd_ready", {7'd0, cmd_ready}, 8'd1);
            check("clr_acc", acc, m_acc);
        end
    endtask

    initial begin
        logic [2:0] rf;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_funct = 3'd0; cmd_a = 8'h00; cmd_b = 8'h00;
        cmd_use_acc = 1'b0; rsp_ready = 1'b0; err_clear = 1'b0;
        model_reset();
        #12;
        // reset state
        check("rst_state", {6'd0, seq_state}, 8'd0);
        check("rst_acc", acc, 8'h00);
        check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_err", {7'd0, rsp_err}, 8'd0);
        check("rst_rsp_flags", {6'd0, rsp_flags}, 8'd0);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_alu_funct", {5'd0, alu_funct}, 8'd0);
        check("rst_op_count", op_count, 8'h00);
        check("rst_err_count", err_count, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);

        // directed: simple add, chain into xor with acc, overflow fault
        do_op(3'd0, 8'h10, 8'h20, 1'b0, 0, 1'b0);
        check("add_acc", acc, 8'h30);
        do_op(3'd0, 8'h05, 8'h03, 1'b0, 0, 1'b0);
        do_op(3'd6, 8'h00, 8'hFF, 1'b1, 0, 1'b0);
        check("chain_acc", acc, 8'hF7);
        do_op(3'd0, 8'hFF, 8'h01, 1'b0, 0, 1'b0);
        check("fault_acc_kept", acc, 8'hF7);
        check("fault_err_count", err_count, 8'h01);
        // held response and err_clear during a pending error response
        do_op(3'd5, 8'h0F, 8'hA0, 1'b0, 5, 1'b0);
        do_op(3'd2, 8'h81, 8'h00, 1'b0, 2, 1'b1);
        do_op(3'd3, 8'h02, 8'h00, 1'b1, 0, 1'b0);

        // randomized ops
        for (int i = 0; i < 60; i++) begin
            rf = 3'($urandom_range(0, 7));
            do_op(rf, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of the execute cycle
        cmd_valid = 1'b1; cmd_funct = 3'd0; cmd_a = 8'h11; cmd_b = 8'h22; cmd_use_acc = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("pre_rst_arith", {6'd0, seq_state}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_state", {6'd0, seq_state}, 8'd0);
        check("midrst_acc", acc, 8'h00);
        check("midrst_valid", {7'd0, rsp_valid}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("midrst_no_rsp", {7'd0, rsp_valid}, 8'd0);
        check("midrst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        check("midrst_op_count", op_count, 8'h00);

        // op_count wrap after 256 successful logic ops
        for (int i = 0; i < 256; i++) begin
            rf = 3'($urandom_range(4, 7));
            do_op(rf, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0);
            if (i == 254) check("op_count_ff", op_count, 8'hFF);
        end
        check("op_count_wrap", op_count, 8'h00);

        // err_count saturation after more than 255 faults
        for (int i = 0; i < 257; i++) begin
            do_op(3'd0, 8'hF0 | 8'($urandom_range(0, 15)), 8'h10, 1'b0, 0, 1'($urandom_range(0, 1)));
        end
        check("err_count_sat", err_count, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
